// File: rtl/uart_in_if.sv
// Receive-side bundle of uart_in: serial line in, framed byte, strobes and status out.
interface uart_in_if;
  logic       rx;
  logic [7:0] UART_RX_Data_Out;
  logic       UART_RX_Ready_Out;
  logic       frame_error;
  logic       idle;

  // The receiver is the source of received data.
  modport master (
    input  rx,
    output UART_RX_Data_Out,
    output UART_RX_Ready_Out,
    output frame_error,
    output idle
  );

  // Consumer side; also drives the line in a bench.
  modport slave (
    output rx,
    input  UART_RX_Data_Out,
    input  UART_RX_Ready_Out,
    input  frame_error,
    input  idle
  );
endinterface

// File: rtl/uart_in.sv
// Byte-wide UART receiver: 1 start, 8 data (LSB first), 1 stop, no parity.
// Bits are sampled at their centre; a low stop bit flags a framing error and parks the
// receiver until the line returns high, so a held break yields exactly one error.
module uart_in #(
  parameter int unsigned CLOCK_RATE = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600
) (
  input logic       clk,
  input logic       rst,
  uart_in_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic             s1, rx_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             ferr_q, ferr_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      s1   <= bus.rx;
      rx_s <= s1;
    end
  end

  // State, counters, shift register and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic; the counter restarts at every sample point so it never overruns.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;  // start bit did not hold to mid-bit: glitch
          end else begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
      end
      StData: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = StStop;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StStop: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = StIdle;  // back in idle half a bit early to catch a zero-gap start
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign bus.UART_RX_Data_Out  = data_q;
  assign bus.UART_RX_Ready_Out = ready_q;
  assign bus.frame_error       = ferr_q;
  assign bus.idle              = (state_q == StIdle);

endmodule

// File: doc/uart_in.md
# uart_in

Byte-wide UART receiver, the receive-side counterpart of the team's UART transmitter; it shares the same `CLOCK_RATE`/`BAUD_RATE` parameterisation and frame format (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It synchronises the asynchronous `rx` line, validates the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit. It presents each received byte with a one-cycle ready strobe, or flags a framing error. It sits between the board RX pin and any consumer logic.

## Interface
- `CLOCK_RATE`, 100_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in baud.
- Derived, not overridable: `CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE` (integer division); `HALF_BIT = CLKS_PER_BIT / 2`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial input; idles high.
- `UART_RX_Data_Out`  out  8  last correctly framed byte; holds its value until the next good frame.
- `UART_RX_Ready_Out`  out  1  one-cycle pulse; `UART_RX_Data_Out` is valid and new on this cycle.
- `frame_error`  out  1  one-cycle pulse; the stop bit sampled 0.
- `idle`  out  1  high when the receiver is in IDLE, waiting for a start bit.

## Operation
- Input sync: two flops, `rx` -> `s1` -> `rx_s`. Both reset to 1. All decisions use `rx_s` only.
- Baud counter: width `$clog2(CLKS_PER_BIT)+1`. Cleared on every state change; otherwise increments each cycle. Never free-runs past its compare value.
- Bit index: 3 bits, counting 0..7. Shift register: 8 bits, filled LSB first (`shift[bit_idx] <= rx_s`).
- States:
  - IDLE: `idle`=1. When `rx_s`==0, go to START and clear the counter.
  - START: when counter == `HALF_BIT`-1, sample `rx_s`. If 1 (glitch), return to IDLE. If 0, go to DATA and set `bit_idx`=0.
  - DATA: when counter == `CLKS_PER_BIT`-1, store `rx_s` into `shift[bit_idx]`. After bit 7, go to STOP; otherwise increment `bit_idx`.
  - STOP: when counter == `CLKS_PER_BIT`-1, sample `rx_s`.
    - If 1: `UART_RX_Data_Out` <= `shift`, pulse `UART_RX_Ready_Out`, go to IDLE.
    - If 0: pulse `frame_error`, leave the data output unchanged, go to BREAK.
  - BREAK: wait until `rx_s`==1, then go to IDLE. A held-low line (break) must not produce repeated frames or errors.
- `UART_RX_Ready_Out` and `frame_error` are mutually exclusive and never high two consecutive cycles.
- Reset values: `UART_RX_Data_Out`=0x00, `UART_RX_Ready_Out`=0, `frame_error`=0, `idle`=1, state IDLE, counters 0, shift register 0.
- Reset mid-frame: abort in the same cycle, no strobe, and return to IDLE. A line still low after reset is treated as a start bit once `rx_s` shows 0; no special handling is required.
- No input handshake: the consumer must take data on the strobe. The next frame may overwrite the data one frame-time later.

## Timing
- Let E be the first rising edge at which `rx`=0 is captured into `s1`.
- `rx_s`=0 at E+1. START is entered at E+2.
- Start sample at E+2+`HALF_BIT`.
- Data bit k is sampled at E+2+`HALF_BIT`+(k+1)·`CLKS_PER_BIT`, for k=0..7.
- Stop sample at E+2+`HALF_BIT`+9·`CLKS_PER_BIT`. The ready strobe or `frame_error` is high in the cycle after that edge.
- Bench tolerance on these edges: ±1 cycle.
- The strobe occurs about half a bit before the stop bit ends, and IDLE is re-entered on the same edge. A back-to-back start bit with zero idle time is therefore caught.
- Tolerated baud mismatch: at least ±3 % for `CLKS_PER_BIT` ≥ 16.

## Test plan
Use `CLOCK_RATE`=1_000_000 and `BAUD_RATE`=100_000, giving `CLKS_PER_BIT`=10 and `HALF_BIT`=5.
- Single frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop 1) -> exactly one `UART_RX_Ready_Out` pulse with data 0xA5; `frame_error` stays 0; `idle`=0 during the frame and 1 after.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three strobes carrying 0x00, 0xFF, 0x3C in order, ≈100 cycles apart.
- `rx` low for 3 cycles, then high -> no strobe, no `frame_error`, `idle` returns to 1 within 8 cycles.
- Frame 0x55 with stop bit 0, `rx` then held low 50 cycles, then high, then frame 0x81 -> one `frame_error` pulse and the data output still 0x00; afterwards one strobe with data 0x81 and no further errors.
- `rst` asserted for 1 cycle during data bit 4 of frame 0xC3 -> no strobe; all outputs at their reset values on the next cycle; a subsequent 0x7E frame is received correctly.
- Frame 0x96 sent at +3 % bit period (10.3 cycles/bit) -> data 0x96 with no `frame_error`.
